// File: rtl/udma_l2_responder.sv
// udma_l2_responder
// -----------------
// Terminates the uDMA read-only (ro) and write-only (wo) L2 master ports on a
// single word-wide memory array. The ro and wo requests are arbitrated
// round-robin, so at most one access happens per cycle. Grants are
// combinational. Responses arrive exactly one cycle after the grant edge.
// Accesses whose word index falls outside the array are still granted. Such a
// write is dropped, such a read returns 0xBADACCE5, and err_o pulses in the
// response cycle.
//
// Optional build macro: UDMA_L2_RESP_STALL_EN
//   When defined, an 8-bit LFSR (seed 0xA5) randomly suppresses both grants
//   to create backpressure. When undefined, no LFSR exists.
//
// Ports:
//   sys_clk_i, sys_rst_ni          clock, asynchronous active-low reset
//   ro_*/wo_* req/wen/addr/be/wdata  request side (wen: 1 = read, 0 = write)
//   ro_*/wo_* gnt                  grant, combinational in the request cycle
//   ro_*/wo_* rvalid/rdata         registered response; rdata holds when idle
//   err_o                          one-cycle pulse for an out-of-range access
module udma_l2_responder #(
  parameter int unsigned L2_DATA_WIDTH = 32,
  parameter int unsigned MEM_WORDS     = 1024,
  parameter logic [31:0] ADDR_OFFSET   = 32'h1C00_0000
) (
  input  logic                       sys_clk_i,
  input  logic                       sys_rst_ni,
  input  logic                       ro_req_i,
  input  logic                       ro_wen_i,
  input  logic [31:0]                ro_addr_i,
  input  logic [L2_DATA_WIDTH/8-1:0] ro_be_i,
  input  logic [L2_DATA_WIDTH-1:0]   ro_wdata_i,
  output logic                       ro_gnt_o,
  output logic                       ro_rvalid_o,
  output logic [L2_DATA_WIDTH-1:0]   ro_rdata_o,
  input  logic                       wo_req_i,
  input  logic                       wo_wen_i,
  input  logic [31:0]                wo_addr_i,
  input  logic [L2_DATA_WIDTH/8-1:0] wo_be_i,
  input  logic [L2_DATA_WIDTH-1:0]   wo_wdata_i,
  output logic                       wo_gnt_o,
  output logic                       wo_rvalid_o,
  output logic [L2_DATA_WIDTH-1:0]   wo_rdata_o,
  output logic                       err_o
);

  localparam int unsigned BE_W      = L2_DATA_WIDTH / 8;
  localparam int unsigned IDX_SHIFT = $clog2(BE_W);
  localparam int unsigned IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] BAD_PATTERN = 32'hBADA_CCE5;

  typedef enum logic {PRIO_RO = 1'b0, PRIO_WO = 1'b1} prio_e;

  prio_e prio_reg, prio_next;
  logic  stall;

`ifdef UDMA_L2_RESP_STALL_EN
  // Fibonacci LFSR, taps 8,6,5,4. Bit 0 of the current value gates the grants.
  logic [7:0] lfsr_reg;

  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      lfsr_reg <= 8'hA5;
    end else begin
      lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
    end
  end

  assign stall = lfsr_reg[0];
`else
  assign stall = 1'b0;
`endif

  // Arbitration. Grants are held low while reset is asserted. During a
  // stall cycle no grant is given and the priority does not change.
  always_comb begin
    ro_gnt_o  = 1'b0;
    wo_gnt_o  = 1'b0;
    prio_next = prio_reg;
    if (sys_rst_ni && !stall) begin
      if (ro_req_i && wo_req_i) begin
        if (prio_reg == PRIO_RO) begin
          ro_gnt_o  = 1'b1;
          prio_next = PRIO_WO;
        end else begin
          wo_gnt_o  = 1'b1;
          prio_next = PRIO_RO;
        end
      end else begin
        ro_gnt_o = ro_req_i;
        wo_gnt_o = wo_req_i;
      end
    end
  end

  // Select the winning request. When neither port is granted, the selection
  // is irrelevant because access is low.
  logic                     access;
  logic                     sel_wen;
  logic [31:0]              sel_addr;
  logic [BE_W-1:0]          sel_be;
  logic [L2_DATA_WIDTH-1:0] sel_wdata;
  logic [31:0]              offset;
  logic [31:0]              idx_full;
  logic                     in_range;
  logic [IDX_W-1:0]         idx;

  assign access    = ro_gnt_o | wo_gnt_o;
  assign sel_wen   = wo_gnt_o ? wo_wen_i   : ro_wen_i;
  assign sel_addr  = wo_gnt_o ? wo_addr_i  : ro_addr_i;
  assign sel_be    = wo_gnt_o ? wo_be_i    : ro_be_i;
  assign sel_wdata = wo_gnt_o ? wo_wdata_i : ro_wdata_i;

  // Addresses below ADDR_OFFSET wrap to a huge offset, so they fall out of
  // range naturally.
  assign offset   = sel_addr - ADDR_OFFSET;
  assign idx_full = offset >> IDX_SHIFT;
  assign in_range = (idx_full < MEM_WORDS);
  assign idx      = idx_full[IDX_W-1:0];

  // The out-of-range read pattern is replicated or truncated to the word width.
  logic [L2_DATA_WIDTH-1:0] bad_word;
  for (genvar gi = 0; gi < L2_DATA_WIDTH; gi++) begin : g_bad
    assign bad_word[gi] = BAD_PATTERN[gi % 32];
  end

  // Storage array with byte-enable writes and a registered read port. This
  // block has no reset, so the array contents survive a reset.
  logic [L2_DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic [L2_DATA_WIDTH-1:0] mem_q;

  always_ff @(posedge sys_clk_i) begin
    if (access && in_range) begin
      if (sel_wen) begin
        mem_q <= mem[idx];
      end else begin
        for (int b = 0; b < BE_W; b++) begin
          if (sel_be[b]) begin
            mem[idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
          end
        end
      end
    end
  end

  // Response path. Only one response is produced per cycle, so both ports
  // share a single data mux. Each port keeps a hold register so that its
  // rdata stays stable between responses.
  logic                     ro_rvalid_reg, wo_rvalid_reg, err_reg;
  logic                     resp_rd_reg, resp_oor_reg;
  logic [L2_DATA_WIDTH-1:0] ro_hold_reg, wo_hold_reg;
  logic [L2_DATA_WIDTH-1:0] resp_data;

  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      prio_reg      <= PRIO_RO;
      ro_rvalid_reg <= 1'b0;
      wo_rvalid_reg <= 1'b0;
      err_reg       <= 1'b0;
      resp_rd_reg   <= 1'b0;
      resp_oor_reg  <= 1'b0;
      ro_hold_reg   <= '0;
      wo_hold_reg   <= '0;
    end else begin
      prio_reg      <= prio_next;
      ro_rvalid_reg <= ro_gnt_o;
      wo_rvalid_reg <= wo_gnt_o;
      err_reg       <= access && !in_range;
      resp_rd_reg   <= sel_wen;
      resp_oor_reg  <= !in_range;
      if (ro_rvalid_reg) begin
        ro_hold_reg <= ro_rdata_o;
      end
      if (wo_rvalid_reg) begin
        wo_hold_reg <= wo_rdata_o;
      end
    end
  end

  assign resp_data   = !resp_rd_reg ? '0 : (resp_oor_reg ? bad_word : mem_q);
  assign ro_rvalid_o = ro_rvalid_reg;
  assign wo_rvalid_o = wo_rvalid_reg;
  assign ro_rdata_o  = ro_rvalid_reg ? resp_data : ro_hold_reg;
  assign wo_rdata_o  = wo_rvalid_reg ? resp_data : wo_hold_reg;
  assign err_o       = err_reg;

endmodule

// File: tb/tb_udma_l2_responder.sv
// Testbench for udma_l2_responder (default parameters). It drives randomized
// and directed traffic on both ports. The expected results come from a
// word-array reference model with a round-robin arbiter.
module tb_udma_l2_responder;

  localparam logic [31:0] BASE = 32'h1C00_0000;

  typedef logic [68:0] vec_t;   // {gnt_ro, gnt_wo, rv_ro, rv_wo, err, rdata_ro, rdata_wo}

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ro_req_i = 1'b0, ro_wen_i = 1'b0, wo_req_i = 1'b0, wo_wen_i = 1'b0;
  logic [31:0] ro_addr_i = '0, wo_addr_i = '0, ro_wdata_i = '0, wo_wdata_i = '0;
  logic [3:0]  ro_be_i = '0, wo_be_i = '0;
  logic        ro_gnt_o, wo_gnt_o, ro_rvalid_o, wo_rvalid_o, err_o;
  logic [31:0] ro_rdata_o, wo_rdata_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  udma_l2_responder dut (
    .sys_clk_i  (clk),
    .sys_rst_ni (rst_n),
    .ro_req_i   (ro_req_i),
    .ro_wen_i   (ro_wen_i),
    .ro_addr_i  (ro_addr_i),
    .ro_be_i    (ro_be_i),
    .ro_wdata_i (ro_wdata_i),
    .ro_gnt_o   (ro_gnt_o),
    .ro_rvalid_o(ro_rvalid_o),
    .ro_rdata_o (ro_rdata_o),
    .wo_req_i   (wo_req_i),
    .wo_wen_i   (wo_wen_i),
    .wo_addr_i  (wo_addr_i),
    .wo_be_i    (wo_be_i),
    .wo_wdata_i (wo_wdata_i),
    .wo_gnt_o   (wo_gnt_o),
    .wo_rvalid_o(wo_rvalid_o),
    .wo_rdata_o (wo_rdata_o),
    .err_o      (err_o)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_mem [1024];
  bit          m_prio = 1'b0;        // 0: ro wins next contention, 1: wo wins
  logic [31:0] m_ro_hold = '0;
  logic [31:0] m_wo_hold = '0;

`ifdef UDMA_L2_RESP_STALL_EN
  logic [7:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 8'hA5;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end
  function automatic bit m_stall();
    return m_lfsr[0];
  endfunction
`else
  function automatic bit m_stall();
    return 1'b0;
  endfunction
`endif

  function automatic void model_reset();
    m_prio    = 1'b0;
    m_ro_hold = '0;
    m_wo_hold = '0;
  endfunction

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0) begin
      if ($urandom_range(0, 1) == 0) return BASE + 32'd4096 + $urandom_range(0, 255);
      else                           return BASE - 32'd1 - $urandom_range(0, 255);
    end
    return BASE + 4 * $urandom_range(0, 31) + $urandom_range(0, 3);
  endfunction

  // Run one clock cycle. The task drives both ports, advances the model and
  // returns what the DUT showed next to what the model predicts.
  task automatic step(input bit rr, input bit rwen, input logic [31:0] ra, input logic [3:0] rbe,
                      input logic [31:0] rd, input bit wr, input bit wwen, input logic [31:0] wa,
                      input logic [3:0] wbe, input logic [31:0] wd,
                      output vec_t obs, output vec_t expv);
    bit egr, egw, eer, st, wen;
    logic [31:0] a, d, off, data;
    logic [3:0]  be;
    @(negedge clk);
    ro_req_i = rr; ro_wen_i = rwen; ro_addr_i = ra; ro_be_i = rbe; ro_wdata_i = rd;
    wo_req_i = wr; wo_wen_i = wwen; wo_addr_i = wa; wo_be_i = wbe; wo_wdata_i = wd;
    #1;
    obs[68:67] = {ro_gnt_o, wo_gnt_o};
    st  = m_stall();
    egr = 1'b0; egw = 1'b0; eer = 1'b0; data = '0;
    if (!st) begin
      if (rr && wr) begin
        egr = (m_prio == 1'b0);
        egw = (m_prio == 1'b1);
        m_prio = ~m_prio;
      end else begin
        egr = rr;
        egw = wr;
      end
    end
    if (egr || egw) begin
      wen = egr ? rwen : wwen;
      a   = egr ? ra : wa;
      be  = egr ? rbe : wbe;
      d   = egr ? rd : wd;
      off = a - BASE;
      if (off / 4 >= 1024) begin
        eer  = 1'b1;
        data = wen ? 32'hBADA_CCE5 : 32'h0;
      end else if (wen) begin
        data = m_mem[off / 4];
      end else begin
        for (int b = 0; b < 4; b++)
          if (be[b]) m_mem[off / 4][8*b +: 8] = d[8*b +: 8];
      end
      if (egr) m_ro_hold = data;
      else     m_wo_hold = data;
    end
    @(posedge clk);
    #1;
    obs[66:0] = {ro_rvalid_o, wo_rvalid_o, err_o, ro_rdata_o, wo_rdata_o};
    ro_req_i = 1'b0;
    wo_req_i = 1'b0;
    expv = {egr, egw, egr, egw, eer, m_ro_hold, m_wo_hold};
  endtask

  // Single-port transaction. The request is held until the model grants it,
  // bounded to 64 cycles.
  task automatic op(input bit is_wo, input bit wen, input logic [31:0] a, input logic [3:0] be,
                    input logic [31:0] d, output vec_t obs, output vec_t expv, output bit to);
    int n = 0;
    do begin
      if (is_wo) step(1'b0, 1'b1, 32'h0, 4'h0, 32'h0, 1'b1, wen, a, be, d, obs, expv);
      else       step(1'b1, wen, a, be, d, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0, obs, expv);
      n++;
    end while (expv[68:67] == 2'b00 && n < 64);
    to = (expv[68:67] == 2'b00);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    vec_t obs;
    rst_n = 1'b0;
    ro_req_i = 1'b1;
    wo_req_i = 1'b1;
    #12;
    obs = {ro_gnt_o, wo_gnt_o, ro_rvalid_o, wo_rvalid_o, err_o, ro_rdata_o, wo_rdata_o};
    n_vec++;
    if (obs !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected 0", obs);
    end
    $display("reset: outputs %h", obs);
    @(negedge clk);
    ro_req_i = 1'b0;
    wo_req_i = 1'b0;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_contention();
    vec_t obs, expv;
    int grants = 0, rvalids = 0, cyc = 0;
    while (grants < 4 && cyc < 64) begin
      step(1'b1, 1'b0, BASE + 32'd80, 4'hF, $urandom, 1'b1, 1'b0, BASE + 32'd84, 4'hF, $urandom,
           obs, expv);
      cyc++;
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL contention_cycle: got %h expected %h", obs, expv);
      end
      if (expv[68:67] != 2'b00) begin
        n_vec++;
        if (obs[68:67] !== ((grants % 2 == 0) ? 2'b10 : 2'b01)) begin
          n_err++;
          $display("FAIL contention_order: grant %0d got %b expected %b", grants, obs[68:67],
                   (grants % 2 == 0) ? 2'b10 : 2'b01);
        end
        grants++;
      end
      rvalids += int'(obs[66]) + int'(obs[65]);
      $display("contention: cycle %0d gnt %b rvalid %b", cyc, obs[68:67], obs[66:65]);
    end
    step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, obs, expv);
    rvalids += int'(obs[66]) + int'(obs[65]);
    n_vec++;
    if (rvalids != 4 || grants != 4) begin
      n_err++;
      $display("FAIL contention_count: got %0d rvalids/%0d grants expected 4/4", rvalids, grants);
    end
  endtask

  task automatic test_single_write_read();
    vec_t obs, expv;
    bit to;
    op(1'b1, 1'b0, BASE + 32'h10, 4'hF, 32'hDEAD_BEEF, obs, expv, to);
    n_vec++;
    if (to || obs !== expv || obs[65] !== 1'b1 || obs[31:0] !== 32'h0) begin
      n_err++;
      $display("FAIL single_write: got %h expected %h", obs, expv);
    end
    op(1'b0, 1'b1, BASE + 32'h10, 4'h0, 32'h0, obs, expv, to);
    n_vec++;
    if (to || obs !== expv || obs[63:32] !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL single_read: got %h expected %h", obs[63:32], 32'hDEAD_BEEF);
    end
    $display("single: read data %h", obs[63:32]);
  endtask

  task automatic test_byte_enables();
    vec_t obs, expv;
    bit to;
    op(1'b1, 1'b0, BASE + 32'h20, 4'hF, 32'h1122_3344, obs, expv, to);
    op(1'b1, 1'b0, BASE + 32'h20, 4'b0101, 32'hAABB_CCDD, obs, expv, to);
    n_vec++;
    if (to || obs !== expv) begin
      n_err++;
      $display("FAIL be_write: got %h expected %h", obs, expv);
    end
    op(1'b0, 1'b1, BASE + 32'h20, 4'h0, 32'h0, obs, expv, to);
    n_vec++;
    if (to || obs !== expv || obs[63:32] !== 32'h11BB_33DD) begin
      n_err++;
      $display("FAIL be_read: got %h expected %h", obs[63:32], 32'h11BB_33DD);
    end
    $display("byte_enables: read data %h", obs[63:32]);
  endtask

  task automatic test_out_of_range();
    vec_t obs, expv;
    bit to;
    logic [31:0] w0 = $urandom;
    op(1'b1, 1'b0, BASE, 4'hF, w0, obs, expv, to);
    op(1'b0, 1'b1, BASE + 32'd4096, 4'hF, 32'h0, obs, expv, to);
    n_vec++;
    if (to || obs !== expv || obs[63:32] !== 32'hBADA_CCE5 || obs[64] !== 1'b1) begin
      n_err++;
      $display("FAIL oor_read: got %h expected %h", obs, expv);
    end
    op(1'b1, 1'b0, BASE - 32'd4, 4'hF, 32'h5555_AAAA, obs, expv, to);
    n_vec++;
    if (to || obs !== expv || obs[64] !== 1'b1) begin
      n_err++;
      $display("FAIL oor_write: got %h expected %h", obs, expv);
    end
    step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, obs, expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL oor_err_pulse: got %h expected %h", obs, expv);
    end
    op(1'b0, 1'b1, BASE, 4'h0, 32'h0, obs, expv, to);
    n_vec++;
    if (to || obs !== expv || obs[63:32] !== w0) begin
      n_err++;
      $display("FAIL oor_word0: got %h expected %h", obs[63:32], w0);
    end
    $display("out_of_range: word0 %h", obs[63:32]);
  endtask

  task automatic test_random();
    vec_t obs, expv;
    bit to;
    for (int i = 0; i < 32; i++) begin
      op(1'b1, 1'b0, BASE + 4 * i, 4'hF, $urandom, obs, expv, to);
      n_vec++;
      if (to || obs !== expv) begin
        n_err++;
        $display("FAIL prefill %0d: got %h expected %h", i, obs, expv);
      end
    end
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), 4'($urandom), $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), 4'($urandom), $urandom,
           obs, expv);
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL random %0d: got %h expected %h", i, obs, expv);
      end
      $display("random %0d: gnt %b rv %b err %b ro %h wo %h", i, obs[68:67], obs[66:65], obs[64],
               obs[63:32], obs[31:0]);
    end
  endtask

  task automatic test_back_to_back();
    vec_t obs, expv;
    bit to;
    logic [31:0] a, d;
    for (int i = 0; i < 8; i++) begin
      a = BASE + 4 * $urandom_range(0, 31);
      d = $urandom;
      op(1'b1, 1'b0, a, 4'hF, d, obs, expv, to);
      op(1'b0, 1'b1, a, 4'h0, 32'h0, obs, expv, to);
      n_vec++;
      if (to || obs !== expv || obs[63:32] !== d) begin
        n_err++;
        $display("FAIL hazard %0d: got %h expected %h", i, obs[63:32], d);
      end
      $display("back_to_back %0d: addr %h data %h", i, a, obs[63:32]);
    end
  endtask

  task automatic test_reset_mid();
    vec_t obs, expv;
    bit to;
    int n = 0;
    logic [31:0] saved = m_mem[4];
    @(negedge clk);
    ro_req_i = 1'b1; ro_wen_i = 1'b1; ro_addr_i = BASE + 32'h10; ro_be_i = 4'hF;
    #1;
    while (!ro_gnt_o && n < 64) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    ro_req_i = 1'b0;
    rst_n = 1'b0;
    #1;
    obs = {ro_gnt_o, wo_gnt_o, ro_rvalid_o, wo_rvalid_o, err_o, ro_rdata_o, wo_rdata_o};
    n_vec++;
    if (n >= 64 || obs !== '0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: got %h expected 0", obs);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, obs, expv);
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL reset_mid_idle %0d: got %h expected %h", i, obs, expv);
      end
    end
    op(1'b0, 1'b1, BASE + 32'h10, 4'h0, 32'h0, obs, expv, to);
    n_vec++;
    if (to || obs !== expv || obs[63:32] !== saved) begin
      n_err++;
      $display("FAIL reset_mid_read: got %h expected %h", obs[63:32], saved);
    end
    $display("reset_mid: read after release %h", obs[63:32]);
  endtask

  task automatic test_stall_reads();
    vec_t obs, expv;
    int k = 0, cyc = 0;
    while (k < 256 && cyc < 2000) begin
      step(1'b1, 1'b1, BASE + 4 * (k % 32), 4'h0, 32'h0, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0, obs, expv);
      cyc++;
      n_vec++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL stall_read %0d: got %h expected %h", k, obs, expv);
      end
      if (expv[68]) k++;
    end
    n_vec++;
    if (k != 256) begin
      n_err++;
      $display("FAIL stall_reads_done: got %0d expected 256", k);
    end
    $display("stall_reads: %0d reads in %0d cycles", k, cyc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_contention();
    test_single_write_read();
    test_byte_enables();
    test_out_of_range();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_stall_reads();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/udma_l2_responder.md
# udma_l2_responder

Single-port, SRAM-backed L2 responder that terminates the uDMA subsystem's two L2 master ports: the read-only (`ro`) and write-only (`wo`) channels. It arbitrates both request streams round-robin onto one word-wide memory array. It returns grant and response handshakes with fixed one-cycle read latency, and flags out-of-range accesses. It sits below `pulp_io` in standalone IO testbenches and FPGA bring-up, in place of the SoC interconnect plus L2.

## Interface
Parameters:
- `L2_DATA_WIDTH`, 32, data width in bits; must be a power of two, at least 8.
- `MEM_WORDS`, 1024, array depth in words; must be a power of two.
- `ADDR_OFFSET`, 32'h1C00_0000, byte address mapped to word 0.

Ports:
- `sys_clk_i` in 1: single clock.
- `sys_rst_ni` in 1: reset, asynchronous, active-low.
- `ro_req_i`, `wo_req_i` in 1: request, per port.
- `ro_wen_i`, `wo_wen_i` in 1: 1 = read, 0 = write.
- `ro_addr_i`, `wo_addr_i` in 32: byte address.
- `ro_be_i`, `wo_be_i` in `L2_DATA_WIDTH/8`: byte enables.
- `ro_wdata_i`, `wo_wdata_i` in `L2_DATA_WIDTH`: write data.
- `ro_gnt_o`, `wo_gnt_o` out 1: grant; combinational in the request cycle.
- `ro_rvalid_o`, `wo_rvalid_o` out 1: response valid.
- `ro_rdata_o`, `wo_rdata_o` out `L2_DATA_WIDTH`: read data.
- `err_o` out 1: one-cycle pulse, out-of-range access.

## Operation
- **One access per cycle.** A transfer occurs on a port when req && gnt at a rising edge.
- **Arbitration.**
  - If only one port requests, that port is granted.
  - If both ports request, the port named by the priority register is granted. The priority register then flips to the other port.
  - Priority changes only on a contended grant. Reset value = `ro`.
- **Request stability.** A requester holds addr, wen, be and wdata stable until granted. The block does not check this.
- **Address decode.**
  - offset = addr − `ADDR_OFFSET`, computed as 32-bit unsigned with wrap.
  - word index = offset >> log2(`L2_DATA_WIDTH/8`).
  - Low offset bits are ignored.
  - The access is in range iff index < `MEM_WORDS`.
- **Write.** Bytes with be=1 are updated at the grant edge; other bytes are untouched. be=0 is legal and is a no-op.
- **Read.** Array word at index, sampled at the grant edge. be is ignored.
- **Responses.**
  - Every granted transaction, read or write, produces exactly one rvalid on its own port, in order.
  - rdata = read data for reads. rdata = 0 for writes.
  - rdata holds its value when rvalid=0.
- **Out of range.**
  - The request is still granted.
  - A write is dropped.
  - A read returns the constant 32'hBADA_CCE5, replicated or truncated to `L2_DATA_WIDTH`.
  - `err_o` pulses in the response cycle.
- **Hazards.** A write granted in cycle N followed by a read of the same word granted in cycle N+1 returns the new data.
- **Array reset.** Array contents are not reset.

## Timing
- Grant latency: 0 cycles when the port wins arbitration.
- rvalid latency: exactly 1 cycle after the grant edge. rvalid, rdata and `err_o` are registered.
- Back-to-back grants on one port every cycle are allowed. Throughput is 1 transfer/cycle total across both ports.
- Reset values (asserted asynchronously, held until the first edge after release):
  - gnt = 0, forced while reset is asserted.
  - rvalid = 0, rdata = 0, `err_o` = 0.
  - priority = `ro`, LFSR = 8'hA5.
- Reset mid-operation: a pending response is discarded and no rvalid is issued after release. Array contents are preserved.
- No response backpressure exists; requesters always accept rvalid.

## Configuration
- **`UDMA_L2_RESP_STALL_EN` defined:**
  - An 8-bit Fibonacci LFSR with taps 8,6,5,4 and seed 8'hA5 advances every cycle.
  - While lfsr[0]=1, both gnt outputs are forced to 0. Arbitration and priority are frozen during that cycle.
  - Purpose: random backpressure for uDMA stall coverage.
- **Undefined:** no LFSR is built, and grants follow arbitration only.

## Test plan
- **Single write/read:** wo writes 32'hDEAD_BEEF to 0x1C00_0010 with be=4'hF, then ro reads 0x1C00_0010 -> ro_rvalid one cycle after grant, ro_rdata=32'hDEAD_BEEF, wo_rdata=0 on the write response.
- **Byte enables:** word holds 32'h1122_3344; write 32'hAABB_CCDD with be=4'b0101 -> readback 32'h11BB_33DD.
- **Contention:** both ports request continuously for 4 cycles after reset -> grants in order ro, wo, ro, wo; exactly 4 rvalids total, each on the matching port.
- **Out of range:** read at `ADDR_OFFSET`+4·`MEM_WORDS`, and a write at `ADDR_OFFSET`−4 -> both granted; read returns 32'hBADA_CCE5; `err_o` pulses once per access; the array word at index 0 is unchanged.
- **Reset mid-transfer:** assert `sys_rst_ni`=0 in the cycle after a read grant -> no rvalid appears; all outputs are 0 immediately; the next read after release returns the previously written data.
- **Stall build (`UDMA_L2_RESP_STALL_EN`):** 256 back-to-back reads -> every read is eventually granted; gnt is low in every cycle where lfsr[0]=1; data is correct for every read.
